// File: rtl/rf_arb_pkg.sv
// rtl/rf_arb_pkg.sv - shared widths and write-record type for the register-file write arbiter
package rf_arb_pkg;

    localparam int RF_ADDR_W = 5;
    localparam int RF_DATA_W = 32;
    localparam int RF_ZERO_REG = 0;

    // One pending register-file write: destination and value
    typedef struct packed {
        logic [RF_ADDR_W-1:0] addr;
        logic [RF_DATA_W-1:0] data;
    } rf_wr_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin picker: first request at or above ptr wins
module rr_arbiter #(
    parameter int N  = 2,
    parameter int PW = 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [PW-1:0] next_ptr_o
);

    // Scan N positions starting at ptr, wrapping; the first set request wins
    always_comb begin
        logic          found;
        logic [PW-1:0] idx;
        gnt_o      = '0;
        next_ptr_o = ptr_i;
        found      = 1'b0;
        idx        = '0;
        for (int k = 0; k < N; k++) begin
            idx = PW'((int'(ptr_i) + k) % N);
            if (!found && req_i[idx]) begin
                found      = 1'b1;
                gnt_o[idx] = 1'b1;
                next_ptr_o = PW'((int'(idx) + 1) % N);
            end
        end
    end

endmodule

// File: rtl/rf_write_arbiter.sv
// rtl/rf_write_arbiter.sv - shares the register-file write port among NUM_REQ writeback sources; RF_BYPASS_EN forwards the committing write to the read ports
module rf_write_arbiter
    import rf_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = RF_ADDR_W,
    parameter int DATA_W  = RF_DATA_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        grant,
    output logic [(2**ADDR_W)-1:0]    pending,
    output logic [ADDR_W-1:0]         rf_rd_addr,
    output logic [DATA_W-1:0]         rf_rd_w_data,
    input  logic [ADDR_W-1:0]         rs_addr,
    input  logic [ADDR_W-1:0]         rt_addr,
    output logic [ADDR_W-1:0]         rf_rs_addr,
    output logic [ADDR_W-1:0]         rf_rt_addr,
    input  logic [DATA_W-1:0]         rf_rs_data,
    input  logic [DATA_W-1:0]         rf_rt_data,
    output logic [DATA_W-1:0]         rs_data,
    output logic [DATA_W-1:0]         rt_data
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(RF_ZERO_REG);

    logic [NUM_REQ-1:0] full_q, full_d;
    logic [ADDR_W-1:0]  addr_q [NUM_REQ];
    logic [ADDR_W-1:0]  addr_d [NUM_REQ];
    logic [DATA_W-1:0]  data_q [NUM_REQ];
    logic [DATA_W-1:0]  data_d [NUM_REQ];
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [NUM_REQ-1:0] gnt;
    logic [PTR_W-1:0]   next_ptr;
    logic [NUM_REQ-1:0] accept;

    rr_arbiter #(
        .N  (NUM_REQ),
        .PW (PTR_W)
    ) u_rr_arbiter (
        .req_i      (full_q),
        .ptr_i      (ptr_q),
        .gnt_o      (gnt),
        .next_ptr_o (next_ptr)
    );

    assign grant = gnt;
    // A buffer can take a new write if empty or draining this cycle; nothing is accepted in reset
    assign req_ready = rst ? (~full_q | gnt) : '0;
    assign accept    = req_valid & req_ready;

    // Buffer next state: load on accepted non-zero write, otherwise drain on grant
    always_comb begin
        full_d = full_q;
        addr_d = addr_q;
        data_d = data_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (accept[i] && (req_addr[i*ADDR_W +: ADDR_W] != ZERO_ADDR)) begin
                full_d[i] = 1'b1;
                addr_d[i] = req_addr[i*ADDR_W +: ADDR_W];
                data_d[i] = req_data[i*DATA_W +: DATA_W];
            end else if (gnt[i]) begin
                full_d[i] = 1'b0;
            end
        end
        ptr_d = (|gnt) ? next_ptr : ptr_q;
    end

    // Buffer and round-robin pointer registers; reset drops any write still in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            full_q <= '0;
            ptr_q  <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else begin
            full_q <= full_d;
            ptr_q  <= ptr_d;
            for (int i = 0; i < NUM_REQ; i++) begin
                addr_q[i] <= addr_d[i];
                data_q[i] <= data_d[i];
            end
        end
    end

    // Drive the RF write port from the granted buffer; idle drives r0, which the RF ignores
    always_comb begin
        rf_rd_addr   = '0;
        rf_rd_w_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                rf_rd_addr   = addr_q[i];
                rf_rd_w_data = data_q[i];
            end
        end
    end

    // Scoreboard of registers with a buffered write not yet committed
    always_comb begin
        pending = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (full_q[i]) begin
                pending[addr_q[i]] = 1'b1;
            end
        end
        pending[ZERO_ADDR] = 1'b0;
    end

    assign rf_rs_addr = rs_addr;
    assign rf_rt_addr = rt_addr;

`ifdef RF_BYPASS_EN
    // Forward the write committing at the next edge so readers see it this cycle
    always_comb begin
        rs_data = ((rs_addr == rf_rd_addr) && (rf_rd_addr != ZERO_ADDR)) ? rf_rd_w_data : rf_rs_data;
        rt_data = ((rt_addr == rf_rd_addr) && (rf_rd_addr != ZERO_ADDR)) ? rf_rd_w_data : rf_rt_data;
    end
`else
    assign rs_data = rf_rs_data;
    assign rt_data = rf_rt_data;
`endif

endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb/tb_rf_write_arbiter.sv - scoreboard bench for rf_write_arbiter with a behavioural register file
module tb_rf_write_arbiter;

    typedef logic [36:0] ent_t;

    logic        clk;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [9:0]  req_addr;
    logic [63:0] req_data;
    logic [1:0]  grant;
    logic [31:0] pending;
    logic [4:0]  rf_rd_addr;
    logic [31:0] rf_rd_w_data;
    logic [4:0]  rs_addr, rt_addr, rf_rs_addr, rf_rt_addr;
    logic [31:0] rf_rs_data, rf_rt_data, rs_data, rt_data;

    logic [31:0] rf_mem [32];
    ent_t        q0[$];
    ent_t        q1[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [1:0]  last_acc;
    logic [4:0]  a0n, a1n;

    rf_write_arbiter #(.NUM_REQ(2), .ADDR_W(5), .DATA_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_addr     (req_addr),
        .req_data     (req_data),
        .grant        (grant),
        .pending      (pending),
        .rf_rd_addr   (rf_rd_addr),
        .rf_rd_w_data (rf_rd_w_data),
        .rs_addr      (rs_addr),
        .rt_addr      (rt_addr),
        .rf_rs_addr   (rf_rs_addr),
        .rf_rt_addr   (rf_rt_addr),
        .rf_rs_data   (rf_rs_data),
        .rf_rt_data   (rf_rt_data),
        .rs_data      (rs_data),
        .rt_data      (rt_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file without write enable; r0 is hardwired to zero
    always @(posedge clk) begin
        if (rf_rd_addr != 5'd0) rf_mem[rf_rd_addr] <= rf_rd_w_data;
    end
    assign rf_rs_data = (rf_rs_addr == 5'd0) ? 32'd0 : rf_mem[rf_rs_addr];
    assign rf_rt_data = (rf_rt_addr == 5'd0) ? 32'd0 : rf_mem[rf_rt_addr];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_pending();
        logic [31:0] p = '0;
        foreach (q0[j]) p[q0[j][36:32]] = 1'b1;
        foreach (q1[j]) p[q1[j][36:32]] = 1'b1;
        return p;
    endfunction

    // Compare the current write port and pending vector against outstanding accepted writes
    task automatic sb_check();
        ent_t e;
        check("gnt_onehot", 64'($onehot0(grant)), 64'd1);
        check("pending", 64'(pending), 64'(exp_pending()));
        check("gnt_work_conserving", 64'(|grant), 64'((q0.size() + q1.size()) != 0));
        if (grant[0]) begin
            if (q0.size() == 0) check("gnt0_no_entry", 64'(grant[0]), 64'd0);
            else begin
                e = q0.pop_front();
                check("wr0_addr", 64'(rf_rd_addr), 64'(e[36:32]));
                check("wr0_data", 64'(rf_rd_w_data), 64'(e[31:0]));
            end
        end
        if (grant[1]) begin
            if (q1.size() == 0) check("gnt1_no_entry", 64'(grant[1]), 64'd0);
            else begin
                e = q1.pop_front();
                check("wr1_addr", 64'(rf_rd_addr), 64'(e[36:32]));
                check("wr1_data", 64'(rf_rd_w_data), 64'(e[31:0]));
            end
        end
    endtask

    // One cycle: check outputs, drive requests, record accepted writes, advance to next negedge
    task automatic step(input logic [1:0] v, input logic [4:0] a0, input logic [4:0] a1,
                        input logic [31:0] d0, input logic [31:0] d1);
        sb_check();
        req_valid = v;
        req_addr  = {a1, a0};
        req_data  = {d1, d0};
        #1;
        last_acc = req_valid & req_ready;
        if (last_acc[0] && a0 != 5'd0) q0.push_back({a0, d0});
        if (last_acc[1] && a1 != 5'd0) q1.push_back({a1, d1});
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 32; i++) rf_mem[i] = 32'd0;
        rst = 1'b0; req_valid = '0; req_addr = '0; req_data = '0;
        rs_addr = '0; rt_addr = '0; last_acc = '0;
        repeat (2) @(negedge clk);
        check("rst_grant", 64'(grant), 64'd0);
        check("rst_ready", 64'(req_ready), 64'd0);
        check("rst_pending", 64'(pending), 64'd0);
        check("rst_rd_addr", 64'(rf_rd_addr), 64'd0);
        check("rst_rd_data", 64'(rf_rd_w_data), 64'd0);
        rst = 1'b1;
        #1;
        check("rel_ready", 64'(req_ready), 64'd3);

        // Single source write to r5
        step(2'b01, 5'd5, 5'd0, 32'hDEADBEEF, 32'd0);
        check("t2_grant", 64'(grant), 64'd1);
        check("t2_rd_addr", 64'(rf_rd_addr), 64'd5);
        check("t2_pending5", 64'(pending[5]), 64'd1);
        step(2'b00, 5'd0, 5'd0, 32'd0, 32'd0);
        rs_addr = 5'd5;
        #1;
        check("t2_rs_data", 64'(rs_data), 64'hDEADBEEF);
        check("t2_grant_idle", 64'(grant), 64'd0);

        // Contention: pointer sits at 1 after the src0 grant, so src1 goes first
        a0n = 5'd1; a1n = 5'd2;
        for (int k = 0; k < 8; k++) begin
            step(2'b11, a0n, a1n, 32'h1000 + 32'(a0n), 32'h2000 + 32'(a1n));
            if (last_acc[0]) a0n = a0n + 5'd2;
            if (last_acc[1]) a1n = a1n + 5'd2;
            check("t3_grant", 64'(grant), (k % 2 == 0) ? 64'd2 : 64'd1);
            check("t3_acc_any", 64'(|last_acc), 64'd1);
        end
        check("t3_src0_progress", 64'(a0n >= 5'd9), 64'd1);
        check("t3_src1_progress", 64'(a1n >= 5'd10), 64'd1);

        // Reset mid-run while both buffers are full
        rst = 1'b0;
        req_valid = '0;
        #1;
        check("mrst_grant", 64'(grant), 64'd0);
        check("mrst_pending", 64'(pending), 64'd0);
        check("mrst_rd_addr", 64'(rf_rd_addr), 64'd0);
        check("mrst_ready", 64'(req_ready), 64'd0);
        q0.delete();
        q1.delete();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("mrst_rel_ready", 64'(req_ready), 64'd3);

        // Zero register write is accepted and dropped
        step(2'b10, 5'd0, 5'd0, 32'd0, 32'h1234);
        check("t4_accepted", 64'(last_acc), 64'd2);
        check("t4_grant", 64'(grant), 64'd0);
        check("t4_pending", 64'(pending), 64'd0);
        rs_addr = 5'd0;
        #1;
        check("t4_r0", 64'(rs_data), 64'd0);

        // Same destination from both sources: src1 commits last
        step(2'b11, 5'd7, 5'd7, 32'hA, 32'hB);
        check("t5_grant_first", 64'(grant), 64'd1);
        check("t5_pending7", 64'(pending[7]), 64'd1);
        step(2'b00, 5'd0, 5'd0, 32'd0, 32'd0);
        check("t5_grant_second", 64'(grant), 64'd2);
        step(2'b00, 5'd0, 5'd0, 32'd0, 32'd0);
        rs_addr = 5'd7;
        #1;
        check("t5_r7", 64'(rs_data), 64'hB);

        // Bypass of the committing write
        step(2'b01, 5'd9, 5'd0, 32'h11, 32'd0);
        step(2'b00, 5'd0, 5'd0, 32'd0, 32'd0);
        step(2'b01, 5'd9, 5'd0, 32'h55, 32'd0);
        rs_addr = 5'd9;
        rt_addr = 5'd9;
        #1;
        check("t6_rd_addr", 64'(rf_rd_addr), 64'd9);
`ifdef RF_BYPASS_EN
        check("t6_rs_bypass", 64'(rs_data), 64'h55);
        check("t6_rt_bypass", 64'(rt_data), 64'h55);
`else
        check("t6_rs_old", 64'(rs_data), 64'h11);
        check("t6_rt_old", 64'(rt_data), 64'h11);
`endif
        step(2'b00, 5'd0, 5'd0, 32'd0, 32'd0);
        #1;
        check("t6_rs_new", 64'(rs_data), 64'h55);

        // Random traffic through the scoreboard
        for (int k = 0; k < 200; k++) begin
            step(2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                 $urandom, $urandom);
        end
        for (int k = 0; k < 10 && (q0.size() + q1.size()) != 0; k++) begin
            step(2'b00, 5'd0, 5'd0, 32'd0, 32'd0);
        end
        check("drain_empty", 64'(q0.size() + q1.size()), 64'd0);
        sb_check();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
